bldc_velocity_loop: RTL and testbench
=====================================

// Module: bldc_velocity_loop
// PURPOSE
//  Parametrised closed-loop velocity core for one BLDC axis. Replaces the fixed-gain tick-time/LUT/IIR path.
//  Chain: synchronised quadrature decode -> fixed-window tick counting -> slew-limited setpoint -> PI loop with anti-windup.
//  Run-state FSM sequences IDLE/ALIGN/RUN/FAULT. Outputs a drive gain and alignment/enable strobes to the commutation stage.
// PARAMETERS
//  VEL_W          16       signed width of measured/desired velocity (ticks per window)
//  GAIN_W         12       unsigned width of output_gain
//  FRAC_BITS      4        fractional bits of PI accumulator (result >>> FRAC_BITS)
//  K_W            8        unsigned width of kp, ki
//  SAMPLE_CYCLES  50000    clk cycles per velocity window (>=4)
//  ALIGN_CYCLES   1000000  clk cycles spent in ALIGN (>=1)
//  ALIGN_GAIN     256      output_gain driven during ALIGN (< 2^GAIN_W)
//  SLEW_STEP      16       max setpoint change per window
//  STALL_SAMPLES  8        consecutive stalled windows before FAULT
// PORTS
//  clk                        in   1       system clock
//  reset                      in   1       asynchronous, active-low reset
//  enable                     in   1       level; 1 = run motor, 0 = return to IDLE
//  direction                  in   1       1 = negative target velocity
//  desired_velocity           in   VEL_W-1 magnitude of target, ticks/window
//  kp, ki                     in   K_W     PI gains, sampled each window
//  encoder_a, encoder_b       in   1       asynchronous quadrature inputs
//  output_gain                out  GAIN_W  drive magnitude to commutation
//  commutation_enable         out  1       1 in ALIGN and RUN
//  apply_initial_commutation  out  1       1 throughout ALIGN
//  reset_encoder_count        out  1       1-cycle pulse on ALIGN entry
//  measured_velocity          out  VEL_W   signed ticks in last window
//  sample_valid               out  1       1-cycle pulse when measured_velocity updates
//  state                      out  2       00 IDLE, 01 ALIGN, 10 RUN, 11 FAULT
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE; integrator, setpoint, accumulator, timers, stall count 0.
//  Encoder input:
//   - encoder_a/b pass through a 2-flop synchroniser, then Gray decode: +1 for A-leads-B, -1 for B-leads-A.
//   - Two-bit jumps are ignored.
//  Velocity window:
//   - Timer counts 0..SAMPLE_CYCLES-1. At the terminal count, measured_velocity <= accumulator saturated to VEL_W signed.
//   - sample_valid pulses on that same update.
//   - Accumulator restarts at the same edge. A step in that cycle counts toward the new window.
//   - Timer free-runs in all states.
//  Setpoint and PI (RUN only, on each sample_valid):
//   - target = direction ? -desired : +desired.
//   - setpoint moves toward target by min(|target-setpoint|, SLEW_STEP).
//   - err = setpoint - measured_velocity, computed VEL_W+1 wide.
//   - u = (kp*err + integ) >>> FRAC_BITS, clamped to [0, 2^GAIN_W-1]. Negative u gives 0; braking is not supported.
//   - integ += ki*err, clamped to [0, (2^GAIN_W-1)<<FRAC_BITS].
//   - Anti-windup: integ is frozen when u is clamped high and err>0, or clamped low and err<0.
//   - output_gain updates exactly 2 cycles after sample_valid and holds between windows.
//  FSM:
//   - IDLE -> ALIGN when enable=1. Entry pulses reset_encoder_count and clears integ, setpoint and stall count.
//   - ALIGN: output_gain=ALIGN_GAIN. -> RUN after ALIGN_CYCLES cycles. RUN starts with setpoint=0 and output_gain=0.
//   - RUN -> FAULT when STALL_SAMPLES consecutive windows satisfy measured_velocity==0 AND output_gain==2^GAIN_W-1.
//     Any nonzero window clears the stall count.
//   - FAULT: output_gain=0, commutation_enable=0. Held until enable=0.
//   - enable=0 in any state -> IDLE next cycle, gain 0. This has priority over every other transition.
//  Changing kp/ki/desired mid-window: takes effect at the next sample_valid only.
//  Async reset mid-operation: immediate return to reset values. No pulse is emitted on release.
// TESTING
//  1. reset low, toggle encoders -> all outputs 0; after release, state=00 and sample_valid pulses every SAMPLE_CYCLES.
//  2. enable=1 (ALIGN_CYCLES=100) -> reset_encoder_count 1 cycle; state=01, gain=ALIGN_GAIN for 100 cycles; then state=10, gain=0.
//  3. 40 forward steps per window -> measured_velocity=40; reverse -> -40; 2-bit jump injected -> count unchanged.
//  4. desired=100, SLEW_STEP=16, stationary encoder -> setpoint 16,32,...,96,100; gain rises to 4095, integ frozen; FAULT after 8 windows.
//  5. kp=16, ki=0, FRAC_BITS=4, setpoint=50, measured=30 -> output_gain=20, updated 2 cycles after sample_valid.
//  6. enable=0 during RUN or FAULT -> state=00 and gain=0 next cycle; re-enable -> fresh ALIGN with cleared integrator.

Source files
------------

// File: rtl/bldc_velocity_loop_if.sv
// Control/status bundle between the velocity loop and its host / commutation stage.
// The loop core takes the slave side; the host (or bench) takes the master side.
interface bldc_velocity_loop_if #(
  parameter int VEL_W  = 16,
  parameter int GAIN_W = 12,
  parameter int K_W    = 8
);
  logic                     enable;
  logic                     direction;
  logic [VEL_W-2:0]         desired_velocity;
  logic [K_W-1:0]           kp;
  logic [K_W-1:0]           ki;
  logic                     encoder_a;
  logic                     encoder_b;
  logic [GAIN_W-1:0]        output_gain;
  logic                     commutation_enable;
  logic                     apply_initial_commutation;
  logic                     reset_encoder_count;
  logic signed [VEL_W-1:0]  measured_velocity;
  logic                     sample_valid;
  logic [1:0]               state;

  modport master (
    output enable, direction, desired_velocity, kp, ki, encoder_a, encoder_b,
    input  output_gain, commutation_enable, apply_initial_commutation,
           reset_encoder_count, measured_velocity, sample_valid, state
  );

  modport slave (
    input  enable, direction, desired_velocity, kp, ki, encoder_a, encoder_b,
    output output_gain, commutation_enable, apply_initial_commutation,
           reset_encoder_count, measured_velocity, sample_valid, state
  );
endinterface

// File: rtl/bldc_velocity_loop.sv
// BLDC velocity core: quadrature decode, windowed tick count, slew-limited setpoint,
// anti-windup PI, and the run-state FSM.
//  state | meaning
//  IDLE  | drive off, waiting for enable
//  ALIGN | rotor alignment at ALIGN_GAIN for ALIGN_CYCLES clocks
//  RUN   | closed-loop PI drive, stall monitoring
//  FAULT | stalled at full gain; drive off until enable drops
module bldc_velocity_loop #(
  parameter int VEL_W         = 16,
  parameter int GAIN_W        = 12,
  parameter int FRAC_BITS     = 4,
  parameter int K_W           = 8,
  parameter int SAMPLE_CYCLES = 50000,
  parameter int ALIGN_CYCLES  = 1000000,
  parameter int ALIGN_GAIN    = 256,
  parameter int SLEW_STEP     = 16,
  parameter int STALL_SAMPLES = 8
) (
  input logic              clk,
  input logic              reset,
  bldc_velocity_loop_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ALIGN = 2'b01;
  localparam logic [1:0] S_RUN   = 2'b10;
  localparam logic [1:0] S_FAULT = 2'b11;

  localparam int SMP_W = $clog2(SAMPLE_CYCLES);
  localparam int ALN_W = $clog2(ALIGN_CYCLES + 1);
  localparam int STL_W = $clog2(STALL_SAMPLES + 1);
  localparam int ERR_W = VEL_W + 1;
  localparam int INT_W = GAIN_W + FRAC_BITS;
  localparam int PI_W  = ERR_W + K_W + INT_W + 2;

  localparam logic [GAIN_W-1:0]       GAIN_MAX = '1;
  localparam logic signed [31:0]      VEL_MAX  = 32'(2**(VEL_W-1) - 1);
  localparam logic signed [31:0]      VEL_MIN  = -32'(2**(VEL_W-1));
  localparam logic signed [ERR_W-1:0] SLEW_E   = ERR_W'(SLEW_STEP);
  localparam logic signed [PI_W-1:0]  U_MAX    = PI_W'(2**GAIN_W - 1);
  localparam logic signed [PI_W-1:0]  I_MAX    = PI_W'((2**GAIN_W - 1) << FRAC_BITS);

  logic [1:0]               a_sync, b_sync;
  logic                     a_prev, b_prev;
  logic signed [1:0]        step;
  logic signed [31:0]       step_ext;
  logic [SMP_W-1:0]         smp_tmr;
  logic                     smp_tc;
  logic signed [31:0]       win_acc;
  logic signed [VEL_W-1:0]  meas_q, meas_sat;
  logic                     sv_q;

  logic [1:0]               state_q;
  logic [GAIN_W-1:0]        gain_q, gain_next;
  logic                     rec_q;
  logic [ALN_W-1:0]         aln_tmr;
  logic [STL_W-1:0]         stall_cnt;
  logic signed [VEL_W-1:0]  setpoint, sp_next;
  logic [INT_W-1:0]         integ, integ_next;
  logic [K_W-1:0]           kp_q, ki_q;
  logic                     pi_go;

  logic signed [ERR_W-1:0]  tgt, sp_diff, err;
  logic signed [PI_W-1:0]   integ_s, pi_sum, u, int_sum;
  logic                     clamp_hi, clamp_lo, freeze;

  // Forward (A leads B) walks 00 -> 10 -> 11 -> 01; two-bit jumps fall to default.
  always_comb begin
    step = 2'sd0;
    case ({a_prev, b_prev, a_sync[1], b_sync[1]})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: step = 2'sd1;
      4'b1000, 4'b1110, 4'b0111, 4'b0001: step = -2'sd1;
      default:                            step = 2'sd0;
    endcase
  end

  assign step_ext = 32'(step);
  assign smp_tc   = (smp_tmr == SMP_W'(SAMPLE_CYCLES - 1));

  always_comb begin
    if (win_acc > VEL_MAX)      meas_sat = VEL_MAX[VEL_W-1:0];
    else if (win_acc < VEL_MIN) meas_sat = VEL_MIN[VEL_W-1:0];
    else                        meas_sat = win_acc[VEL_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_sync  <= '0;
      b_sync  <= '0;
      a_prev  <= 1'b0;
      b_prev  <= 1'b0;
      smp_tmr <= '0;
      win_acc <= '0;
      meas_q  <= '0;
      sv_q    <= 1'b0;
    end else begin
      a_sync <= {a_sync[0], bus.encoder_a};
      b_sync <= {b_sync[0], bus.encoder_b};
      a_prev <= a_sync[1];
      b_prev <= b_sync[1];
      if (smp_tc) begin
        smp_tmr <= '0;
        win_acc <= step_ext;
        meas_q  <= meas_sat;
        sv_q    <= 1'b1;
      end else begin
        smp_tmr <= smp_tmr + SMP_W'(1);
        win_acc <= win_acc + step_ext;
        sv_q    <= 1'b0;
      end
    end
  end

  always_comb begin
    tgt     = bus.direction ? -$signed(ERR_W'({1'b0, bus.desired_velocity}))
                            :  $signed(ERR_W'({1'b0, bus.desired_velocity}));
    sp_diff = tgt - ERR_W'(setpoint);
    if (sp_diff > SLEW_E)       sp_next = setpoint + VEL_W'(SLEW_STEP);
    else if (sp_diff < -SLEW_E) sp_next = setpoint - VEL_W'(SLEW_STEP);
    else                        sp_next = tgt[VEL_W-1:0];
  end

  // PI evaluated one cycle after the setpoint moves, so gain lands 2 cycles after sample_valid.
  always_comb begin
    err      = ERR_W'(setpoint) - ERR_W'(meas_q);
    integ_s  = PI_W'($signed({1'b0, integ}));
    pi_sum   = PI_W'(err) * PI_W'($signed({1'b0, kp_q})) + integ_s;
    u        = pi_sum >>> FRAC_BITS;
    clamp_lo = u[PI_W-1];
    clamp_hi = !clamp_lo && (u > U_MAX);
    if (clamp_hi)      gain_next = GAIN_MAX;
    else if (clamp_lo) gain_next = '0;
    else               gain_next = u[GAIN_W-1:0];
    int_sum  = integ_s + PI_W'(err) * PI_W'($signed({1'b0, ki_q}));
    if (int_sum[PI_W-1])     integ_next = '0;
    else if (int_sum > I_MAX) integ_next = I_MAX[INT_W-1:0];
    else                     integ_next = int_sum[INT_W-1:0];
    freeze   = (clamp_hi && !err[ERR_W-1] && (err != '0)) || (clamp_lo && err[ERR_W-1]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      gain_q    <= '0;
      rec_q     <= 1'b0;
      aln_tmr   <= '0;
      stall_cnt <= '0;
      setpoint  <= '0;
      integ     <= '0;
      kp_q      <= '0;
      ki_q      <= '0;
      pi_go     <= 1'b0;
    end else begin
      rec_q <= 1'b0;
      pi_go <= sv_q && (state_q == S_RUN);
      if (!bus.enable) begin
        state_q <= S_IDLE;
        gain_q  <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q   <= S_ALIGN;
            rec_q     <= 1'b1;
            aln_tmr   <= ALN_W'(ALIGN_CYCLES - 1);
            gain_q    <= GAIN_W'(ALIGN_GAIN);
            integ     <= '0;
            setpoint  <= '0;
            stall_cnt <= '0;
          end
          S_ALIGN: begin
            if (aln_tmr == '0) begin
              state_q <= S_RUN;
              gain_q  <= '0;
            end else begin
              aln_tmr <= aln_tmr - ALN_W'(1);
            end
          end
          S_RUN: begin
            if (sv_q) begin
              setpoint <= sp_next;
              kp_q     <= bus.kp;
              ki_q     <= bus.ki;
              if (meas_q == '0 && gain_q == GAIN_MAX) begin
                if (stall_cnt == STL_W'(STALL_SAMPLES - 1)) begin
                  state_q <= S_FAULT;
                  gain_q  <= '0;
                end else begin
                  stall_cnt <= stall_cnt + STL_W'(1);
                end
              end else begin
                stall_cnt <= '0;
              end
            end
            if (pi_go) begin
              gain_q <= gain_next;
              if (!freeze) integ <= integ_next;
            end
          end
          default: gain_q <= '0;
        endcase
      end
    end
  end

  assign bus.output_gain               = gain_q;
  assign bus.commutation_enable        = (state_q == S_ALIGN) || (state_q == S_RUN);
  assign bus.apply_initial_commutation = (state_q == S_ALIGN);
  assign bus.reset_encoder_count       = rec_q;
  assign bus.measured_velocity         = meas_q;
  assign bus.sample_valid              = sv_q;
  assign bus.state                     = state_q;

endmodule

// File: tb/tb_bldc_velocity_loop.sv
// Directed bench for bldc_velocity_loop: 80-cycle windows, 100-cycle alignment,
// encoder driven by a background quadrature generator (one step per 2 clocks).
module tb_bldc_velocity_loop;
  logic clk = 1'b0;
  logic reset;

  bldc_velocity_loop_if #(.VEL_W(16), .GAIN_W(12), .K_W(8)) bus ();

  bldc_velocity_loop #(.SAMPLE_CYCLES(80), .ALIGN_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int enc_mode = 0;
  int jump_req = 0;
  int step_req = 0;
  int enc_phase = 0;
  int jump_done = 0;
  int step_done = 0;
  bit enc_div = 1'b0;
  int exp_g[7] = '{255, 765, 1530, 2550, 3825, 4095, 4095};

  // mode 0 hold, 1 forward, 2 reverse; jump/step requests are one-shot extras
  always @(negedge clk) begin
    enc_div = ~enc_div;
    if (jump_req != jump_done) begin
      enc_phase = (enc_phase + 2) % 4;
      jump_done = jump_done + 1;
    end else if (step_req != step_done) begin
      enc_phase = (enc_phase + 1) % 4;
      step_done = step_done + 1;
    end else if (enc_div) begin
      if (enc_mode == 1)      enc_phase = (enc_phase + 1) % 4;
      else if (enc_mode == 2) enc_phase = (enc_phase + 3) % 4;
    end
    case (enc_phase)
      0:       begin bus.encoder_a = 1'b0; bus.encoder_b = 1'b0; end
      1:       begin bus.encoder_a = 1'b1; bus.encoder_b = 1'b0; end
      2:       begin bus.encoder_a = 1'b1; bus.encoder_b = 1'b1; end
      default: begin bus.encoder_a = 1'b0; bus.encoder_b = 1'b1; end
    endcase
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_sv(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.sample_valid && n < 400);
    if (!bus.sample_valid) chk("sv_timeout", int'(bus.sample_valid), 1);
  endtask

  initial begin
    int n;
    int m;
    reset = 1'b0;
    bus.enable = 1'b0;
    bus.direction = 1'b0;
    bus.desired_velocity = '0;
    bus.kp = '0;
    bus.ki = '0;

    // reset held while the encoder toggles
    enc_mode = 1;
    tick(6);
    chk("rst_gain", int'(bus.output_gain), 0);
    chk("rst_comm_en", int'(bus.commutation_enable), 0);
    chk("rst_align", int'(bus.apply_initial_commutation), 0);
    chk("rst_rec", int'(bus.reset_encoder_count), 0);
    chk("rst_meas", int'($signed(bus.measured_velocity)), 0);
    chk("rst_sv", int'(bus.sample_valid), 0);
    chk("rst_state", int'(bus.state), 0);
    enc_mode = 0;
    @(negedge clk);
    reset = 1'b1;
    wait_sv(n);
    chk("first_window", n, 80);
    chk("idle_state", int'(bus.state), 0);
    wait_sv(n);
    chk("window_period", n, 80);

    // enable -> alignment
    tick(3);
    bus.enable = 1'b1;
    tick(1);
    chk("align_state", int'(bus.state), 1);
    chk("align_rec", int'(bus.reset_encoder_count), 1);
    chk("align_gain", int'(bus.output_gain), 256);
    chk("align_comm_en", int'(bus.commutation_enable), 1);
    chk("align_apply", int'(bus.apply_initial_commutation), 1);
    n = 1;
    tick(1);
    chk("rec_pulse_len", int'(bus.reset_encoder_count), 0);
    while (bus.state == 2'b01 && n < 300) begin
      n++;
      tick(1);
    end
    chk("align_len", n, 100);
    chk("run_state", int'(bus.state), 2);
    chk("run_gain0", int'(bus.output_gain), 0);
    chk("run_apply", int'(bus.apply_initial_commutation), 0);

    // measured velocity: forward, reverse, jumps, single step
    enc_mode = 1;
    repeat (3) wait_sv(n);
    chk("meas_fwd", int'($signed(bus.measured_velocity)), 40);
    enc_mode = 2;
    repeat (3) wait_sv(n);
    chk("meas_rev", int'($signed(bus.measured_velocity)), -40);
    enc_mode = 0;
    repeat (2) wait_sv(n);
    tick(3);
    jump_req++;
    tick(10);
    jump_req++;
    wait_sv(n);
    chk("jump_ignored", int'($signed(bus.measured_velocity)), 0);
    tick(3);
    step_req++;
    wait_sv(n);
    chk("single_step", int'($signed(bus.measured_velocity)), 1);
    chk("zero_gain_run", int'(bus.output_gain), 0);

    // slew-limited ramp into saturation, then stall fault
    tick(3);
    bus.kp = 8'd255;
    bus.ki = 8'd255;
    bus.desired_velocity = 15'd100;
    for (int k = 0; k < 7; k++) begin
      wait_sv(n);
      tick(1);
      if (k == 0) chk("gain_not_yet", int'(bus.output_gain), 0);
      tick(1);
      chk($sformatf("ramp_gain%0d", k), int'(bus.output_gain), exp_g[k]);
    end
    repeat (5) wait_sv(n);
    tick(3);
    chk("still_run", int'(bus.state), 2);
    repeat (3) wait_sv(n);
    tick(3);
    chk("stall_fault", int'(bus.state), 3);
    chk("fault_gain", int'(bus.output_gain), 0);
    chk("fault_comm_en", int'(bus.commutation_enable), 0);
    tick(50);
    chk("fault_hold", int'(bus.state), 3);
    bus.enable = 1'b0;
    tick(1);
    chk("fault_to_idle", int'(bus.state), 0);
    chk("idle_gain", int'(bus.output_gain), 0);

    // re-enable: fresh alignment, cleared integrator, P-only gain of 20
    bus.kp = 8'd16;
    bus.ki = 8'd0;
    bus.desired_velocity = 15'd60;
    enc_mode = 1;
    tick(20);
    bus.enable = 1'b1;
    tick(1);
    chk("realign_state", int'(bus.state), 1);
    chk("realign_rec", int'(bus.reset_encoder_count), 1);
    m = 0;
    do begin
      wait_sv(n);
      m++;
    end while (bus.state != 2'b10 && m < 5);
    chk("pi_meas", int'($signed(bus.measured_velocity)), 40);
    tick(2);
    chk("pi_w1", int'(bus.output_gain), 0);
    wait_sv(n);
    tick(2);
    chk("pi_w2", int'(bus.output_gain), 0);
    wait_sv(n);
    tick(2);
    chk("pi_w3", int'(bus.output_gain), 8);
    wait_sv(n);
    tick(1);
    chk("pi_w4_early", int'(bus.output_gain), 8);
    tick(1);
    chk("pi_w4", int'(bus.output_gain), 20);
    tick(40);
    chk("pi_hold", int'(bus.output_gain), 20);

    // enable drop in RUN, then async reset mid-alignment
    bus.enable = 1'b0;
    tick(1);
    chk("run_to_idle", int'(bus.state), 0);
    chk("run_idle_gain", int'(bus.output_gain), 0);
    bus.enable = 1'b1;
    tick(30);
    #2;
    reset = 1'b0;
    #1;
    chk("async_state", int'(bus.state), 0);
    chk("async_gain", int'(bus.output_gain), 0);
    chk("async_comm_en", int'(bus.commutation_enable), 0);
    @(negedge clk);
    reset = 1'b1;
    wait_sv(n);
    chk("post_reset_window", n, 80);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
